// File: rtl/apb_rb_controller_p_if.sv
// APB3 slave bus plus register-bank side channel for apb_rb_controller_p.
// The slave modport is the controller's view; the master modport is the
// view of whatever drives the APB bus and models the register bank.
interface apb_rb_controller_p_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8
) ();
    // APB side
    logic [ADDR_W-1:0] paddr;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;
    logic              apb_rd_done;

    // Register-bank side
    logic              rb_ack;
    logic [DATA_W-1:0] rb_rdata;
    logic              rb_rd_done;
    logic [ADDR_W-1:0] rb_addr;
    logic [DATA_W-1:0] rb_wdata;
    logic              rb_req;
    logic              rb_rw;
    logic              rb_idle;

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata,
        input  rb_ack, rb_rdata, rb_rd_done,
        output prdata, pready, pslverr, apb_rd_done,
        output rb_addr, rb_wdata, rb_req, rb_rw, rb_idle
    );

    modport master (
        output paddr, psel, penable, pwrite, pwdata,
        output rb_ack, rb_rdata, rb_rd_done,
        input  prdata, pready, pslverr, apb_rd_done,
        input  rb_addr, rb_wdata, rb_req, rb_rw, rb_idle
    );
endinterface

// File: rtl/apb_rb_controller_p.sv
// APB3 slave controller fronting the APB-to-burst register bank.
// Setup phase latches the request and decodes it; REQ holds rb_req until the
// bank acknowledges or a bounded timeout expires; DONE/ERR present a
// one-cycle registered completion. A local read-only status register reports
// {busy, sticky read-done}.
module apb_rb_controller_p #(
    parameter int ADDR_W      = 9,
    parameter int DATA_W      = 8,
    parameter int LEN_ADDR    = 256,
    parameter int STATUS_ADDR = 257,
    parameter int START_ADDR  = 258,
    parameter int TIMEOUT     = 16
) (
    input  logic clk,
    input  logic rst_n,
    apb_rb_controller_p_if.slave bus
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [ADDR_W-1:0] LEN_A    = ADDR_W'(LEN_ADDR);
    localparam logic [ADDR_W-1:0] STATUS_A = ADDR_W'(STATUS_ADDR);
    localparam logic [ADDR_W-1:0] START_A  = ADDR_W'(START_ADDR);
    localparam logic [CNT_W-1:0]  TO_C     = CNT_W'(TIMEOUT);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [1:0] ST_ERR  = 2'd3;

    // Status word: bit1 = burst configured/busy (~rb_idle), bit0 = sticky read-done.
    function automatic logic [DATA_W-1:0] status_word(input logic idle, input logic sticky);
        logic [DATA_W-1:0] w;
        w    = {DATA_W{1'b0}};
        w[1] = ~idle;
        w[0] = sticky;
        return w;
    endfunction

    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_inc_s;
    logic [ADDR_W-1:0] rb_addr_r;
    logic [DATA_W-1:0] rb_wdata_r;
    logic              rb_rw_r;
    logic              rb_req_r;
    logic [DATA_W-1:0] prdata_r;
    logic              pready_r;
    logic              pslverr_r;
    logic              rb_idle_r;
    logic              sticky_r;

    logic              setup_s;
    logic              addr_bad_s;
    logic              status_hit_s;
    logic              complete_s;

    // Setup-phase detection, address decode and completion qualifier.
    always_comb begin
        setup_s      = (state_r == ST_IDLE) && bus.psel && !bus.penable;
        addr_bad_s   = (bus.paddr > START_A);
        status_hit_s = (bus.paddr == STATUS_A);
        complete_s   = (state_r == ST_DONE) && bus.psel && bus.penable;
        cnt_inc_s    = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    // Next-state logic; a dropped psel aborts any in-flight transfer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (setup_s) begin
                    if (addr_bad_s || (bus.pwrite && status_hit_s)) begin
                        state_nxt_s = ST_ERR;
                    end else if (status_hit_s) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_REQ;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (!bus.psel) begin
                    state_nxt_s = ST_IDLE;
                end else if (bus.rb_ack) begin
                    // ack on the final allowed cycle still wins over timeout
                    state_nxt_s = ST_DONE;
                end else if (cnt_inc_s == TO_C) begin
                    state_nxt_s = ST_ERR;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            ST_ERR:  state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Ack-wait counter: cleared on entry to REQ, counts each REQ cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (setup_s) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (state_r == ST_REQ) begin
            cnt_r <= cnt_inc_s;
        end
    end

    // Latch the APB request into the register-bank address/data/direction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rb_addr_r  <= {ADDR_W{1'b0}};
            rb_wdata_r <= {DATA_W{1'b0}};
            rb_rw_r    <= 1'b0;
        end else if (setup_s) begin
            rb_addr_r  <= bus.paddr;
            rb_wdata_r <= bus.pwdata;
            rb_rw_r    <= bus.pwrite;
        end
    end

    // Registered request and completion flags, all derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rb_req_r  <= 1'b0;
            pready_r  <= 1'b0;
            pslverr_r <= 1'b0;
        end else begin
            rb_req_r  <= (state_nxt_s == ST_REQ);
            pready_r  <= (state_nxt_s == ST_DONE) || (state_nxt_s == ST_ERR);
            pslverr_r <= (state_nxt_s == ST_ERR);
        end
    end

    // Read data: status word on a status read, bank data on an acked read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prdata_r <= {DATA_W{1'b0}};
        end else if (setup_s && !bus.pwrite && status_hit_s) begin
            prdata_r <= status_word(rb_idle_r, sticky_r);
        end else if ((state_r == ST_REQ) && bus.psel && bus.rb_ack && !rb_rw_r) begin
            prdata_r <= bus.rb_rdata;
        end
    end

    // Burst-config idle flag, changed only by completed LEN/START writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rb_idle_r <= 1'b1;
        end else if (complete_s && rb_rw_r && (rb_addr_r == LEN_A)) begin
            rb_idle_r <= 1'b0;
        end else if (complete_s && rb_rw_r && (rb_addr_r == START_A)) begin
            rb_idle_r <= 1'b1;
        end
    end

    // Sticky read-done: a new pulse takes priority over a status-read clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_r <= 1'b0;
        end else if (bus.rb_rd_done) begin
            sticky_r <= 1'b1;
        end else if (complete_s && !rb_rw_r && (rb_addr_r == STATUS_A)) begin
            sticky_r <= 1'b0;
        end
    end

    // pready/pslverr are qualified by the live access phase so an aborted
    // transfer can never show a completion without psel&penable.
    assign bus.pready      = pready_r & bus.psel & bus.penable;
    assign bus.pslverr     = pslverr_r & bus.psel & bus.penable;
    assign bus.prdata      = prdata_r;
    assign bus.apb_rd_done = sticky_r;
    assign bus.rb_addr     = rb_addr_r;
    assign bus.rb_wdata    = rb_wdata_r;
    assign bus.rb_req      = rb_req_r;
    assign bus.rb_rw       = rb_rw_r;
    assign bus.rb_idle     = rb_idle_r;

endmodule

// File: tb/tb_apb_rb_controller_p.sv
// Scoreboard bench for apb_rb_controller_p: the APB driver pushes the
// expected completion, a monitor pops and compares whenever pready is seen.
module tb_apb_rb_controller_p;

    logic clk;
    logic rst_n;

    apb_rb_controller_p_if #(.ADDR_W(9), .DATA_W(8)) bus ();

    apb_rb_controller_p #(
        .ADDR_W(9), .DATA_W(8), .LEN_ADDR(256), .STATUS_ADDR(257),
        .START_ADDR(258), .TIMEOUT(16)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct packed {
        logic [7:0] rdata;
        logic       err;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    int   pushed = 0;
    int   popped = 0;

    // register-bank responder state
    int         ack_delay = -1;
    int         req_cycles = 0;
    int         last_req_len = 0;
    logic [8:0] cap_addr;
    logic [7:0] cap_wdata;
    logic       cap_rw;
    logic [7:0] exp_prdata = 8'h00;
    logic       pulse_at_done = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Register-bank model: acks in the REQ cycle indexed ack_delay (-1 = never).
    initial begin
        forever begin
            @(negedge clk);
            if (bus.rb_req === 1'b1) begin
                if (req_cycles == 0) begin
                    cap_addr  = bus.rb_addr;
                    cap_wdata = bus.rb_wdata;
                    cap_rw    = bus.rb_rw;
                end
                bus.rb_ack = (req_cycles == ack_delay);
                req_cycles++;
                last_req_len = req_cycles;
            end else begin
                bus.rb_ack = 1'b0;
                req_cycles = 0;
            end
        end
    end

    // Monitor: every completion seen on the bus is matched against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.pready === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_pready", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    popped++;
                    check("pslverr", {31'd0, bus.pslverr}, {31'd0, e.err});
                    check("prdata", {24'd0, bus.prdata}, {24'd0, e.rdata});
                end
            end
        end
    end

    // One APB transfer; expected response pushed before the access phase.
    task automatic apb(input logic [8:0] addr, input logic wr, input logic [7:0] wdata,
                       input int delay, input logic [7:0] rb_data, input logic exp_err,
                       input logic [7:0] exp_rd, input int exp_waits, input int exp_req);
        int waits;
        bit seen;
        exp_t e;
        waits = 0;
        seen = 1'b0;
        @(posedge clk); #1;
        last_req_len  = 0;
        ack_delay     = delay;
        bus.rb_rdata  = rb_data;
        bus.paddr     = addr;
        bus.pwrite    = wr;
        bus.pwdata    = wdata;
        bus.psel      = 1'b1;
        bus.penable   = 1'b0;
        if (!wr && !exp_err) exp_prdata = exp_rd;
        e.rdata = exp_prdata;
        e.err   = exp_err;
        sb_q.push_back(e);
        pushed++;
        @(posedge clk); #1;
        bus.penable = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.pready === 1'b1) begin
                seen = 1'b1;
                if (pulse_at_done) bus.rb_rd_done = 1'b1;
                break;
            end
            waits++;
        end
        if (!seen) begin
            check("pready_timeout", 32'd0, 32'd1);
        end
        @(posedge clk); #1;
        bus.rb_rd_done = 1'b0;
        bus.psel       = 1'b0;
        bus.penable    = 1'b0;
        check("wait_states", waits, exp_waits);
        check("rb_req_cycles", last_req_len, exp_req);
    endtask

    task automatic pulse_rd_done();
        @(posedge clk); #1;
        bus.rb_rd_done = 1'b1;
        @(posedge clk); #1;
        bus.rb_rd_done = 1'b0;
    endtask

    initial begin
        bus.paddr      = 9'd0;
        bus.psel       = 1'b0;
        bus.penable    = 1'b0;
        bus.pwrite     = 1'b0;
        bus.pwdata     = 8'd0;
        bus.rb_ack     = 1'b0;
        bus.rb_rdata   = 8'd0;
        bus.rb_rd_done = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_prdata", {24'd0, bus.prdata}, 32'd0);
        check("rst_pready", {31'd0, bus.pready}, 32'd0);
        check("rst_pslverr", {31'd0, bus.pslverr}, 32'd0);
        check("rst_rb_req", {31'd0, bus.rb_req}, 32'd0);
        check("rst_rb_idle", {31'd0, bus.rb_idle}, 32'd1);
        check("rst_apb_rd_done", {31'd0, bus.apb_rd_done}, 32'd0);
        check("rst_rb_addr", {23'd0, bus.rb_addr}, 32'd0);
        rst_n = 1'b1;

        // write, ack in first REQ cycle
        apb(9'h010, 1'b1, 8'h5A, 0, 8'h00, 1'b0, 8'h00, 1, 1);
        check("wr_cap_addr", {23'd0, cap_addr}, 32'h010);
        check("wr_cap_wdata", {24'd0, cap_wdata}, 32'h5A);
        check("wr_cap_rw", {31'd0, cap_rw}, 32'd1);
        // read, ack in third REQ cycle
        apb(9'h020, 1'b0, 8'h00, 2, 8'hC3, 1'b0, 8'hC3, 3, 3);
        check("rd_cap_rw", {31'd0, cap_rw}, 32'd0);
        // decode errors: beyond START_ADDR and a write to STATUS
        apb(9'h103, 1'b1, 8'h11, 0, 8'h00, 1'b1, 8'h00, 0, 0);
        check("err_rb_idle", {31'd0, bus.rb_idle}, 32'd1);
        apb(9'h101, 1'b1, 8'h22, 0, 8'h00, 1'b1, 8'h00, 0, 0);
        check("err2_rb_idle", {31'd0, bus.rb_idle}, 32'd1);
        // timeout, then ack on the last allowed cycle
        apb(9'h030, 1'b0, 8'h00, -1, 8'h99, 1'b1, 8'h00, 16, 16);
        apb(9'h030, 1'b0, 8'h00, 15, 8'h7E, 1'b0, 8'h7E, 16, 16);
        // burst config and sticky flag
        apb(9'h100, 1'b1, 8'h04, 0, 8'h00, 1'b0, 8'h00, 1, 1);
        check("len_rb_idle", {31'd0, bus.rb_idle}, 32'd0);
        pulse_rd_done();
        check("sticky_set", {31'd0, bus.apb_rd_done}, 32'd1);
        apb(9'h101, 1'b0, 8'h00, -1, 8'h00, 1'b0, 8'h03, 0, 0);
        check("sticky_clr", {31'd0, bus.apb_rd_done}, 32'd0);
        apb(9'h102, 1'b1, 8'h01, 1, 8'h00, 1'b0, 8'h00, 2, 2);
        check("start_rb_idle", {31'd0, bus.rb_idle}, 32'd1);
        pulse_rd_done();
        pulse_at_done = 1'b1;
        apb(9'h101, 1'b0, 8'h00, -1, 8'h00, 1'b0, 8'h01, 0, 0);
        pulse_at_done = 1'b0;
        check("sticky_set_wins", {31'd0, bus.apb_rd_done}, 32'd1);

        // reset in the middle of REQ with rb_idle cleared
        apb(9'h100, 1'b1, 8'h08, 0, 8'h00, 1'b0, 8'h00, 1, 1);
        @(posedge clk); #1;
        ack_delay   = -1;
        bus.paddr   = 9'h050;
        bus.pwrite  = 1'b0;
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        @(posedge clk); #1;
        bus.penable = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_req_active", {31'd0, bus.rb_req}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_rb_req", {31'd0, bus.rb_req}, 32'd0);
        check("arst_pready", {31'd0, bus.pready}, 32'd0);
        check("arst_rb_idle", {31'd0, bus.rb_idle}, 32'd1);
        check("arst_sticky", {31'd0, bus.apb_rd_done}, 32'd0);
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        exp_prdata  = 8'h00;
        @(posedge clk); #1;
        rst_n = 1'b1;
        apb(9'h040, 1'b1, 8'hA5, 0, 8'h00, 1'b0, 8'h00, 1, 1);
        check("post_rst_cap_wdata", {24'd0, cap_wdata}, 32'hA5);

        repeat (3) @(posedge clk);
        check("sb_drained", sb_q.size(), 32'd0);
        check("sb_pops", popped, pushed);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
